// File: rtl/base64_sequencer.sv
// -----------------------------------------------------------------------------
// base64_sequencer
//
// Captures eight packed 6-bit words on an accepted start request. It then
// streams Len+1 of them, W0 first, as ASCII characters over a valid/ready
// handshake. Each character uses either the base64 alphabet or the uppercase
// hex alphabet.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   start_i       begin a conversion (honoured only in IDLE)
//   mode_i        0 = base64 map, 1 = hex map (captured on start)
//   len_i         number of sextets to emit minus one (captured on start)
//   din_i         eight packed sextets, W0 = din_i[5:0] .. W7 = din_i[47:42]
//   char_ready_i  downstream can accept char_out_o this cycle
//   sel_o         index of the sextet currently presented
//   sextet_o      captured word W[sel_o]
//   char_out_o    ASCII character for sextet_o, 8'h00 when not valid
//   char_valid_o  char_out_o is valid
//   busy_o        conversion in progress (SEND or DONE)
//   done_o        one-cycle pulse after the last character handshake
// -----------------------------------------------------------------------------
module base64_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [2:0]  len_i,
  input  logic [47:0] din_i,
  input  logic        char_ready_i,
  output logic [2:0]  sel_o,
  output logic [5:0]  sextet_o,
  output logic [7:0]  char_out_o,
  output logic        char_valid_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q,   sel_d;
  logic [2:0]  len_q,   len_d;
  logic        mode_q,  mode_d;
  logic [47:0] din_q,   din_d;

  logic accept;
  logic handshake;
  logic last;

  assign accept    = (state_q == IDLE) && start_i;
  assign handshake = (state_q == SEND) && char_ready_i;
  assign last      = (sel_q == len_q);

  // Base64 alphabet: A-Z, a-z, 0-9, '+', '/'.
  function automatic logic [7:0] b64_char(input logic [5:0] v);
    logic [7:0] v8;
    v8 = {2'b00, v};
    if (v < 6'd26)       return 8'h41 + v8;
    else if (v < 6'd52)  return 8'h61 + (v8 - 8'd26);
    else if (v < 6'd62)  return 8'h30 + (v8 - 8'd52);
    else if (v == 6'd62) return 8'h2B;
    else                 return 8'h2F;
  endfunction

  // Hex alphabet on the low nibble only; the top two bits are don't-care.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10) return 8'h30 + n8;
    else           return 8'h41 + (n8 - 8'd10);
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SEND;
      SEND:    if (handshake && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured data and sextet index
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d  = sel_q;
    len_d  = len_q;
    mode_d = mode_q;
    din_d  = din_q;
    if (accept) begin
      sel_d  = 3'd0;
      len_d  = len_i;
      mode_d = mode_i;
      din_d  = din_i;
    end else if (handshake && !last) begin
      // sel never passes len, so no wrap from 7 to 0 is possible here.
      sel_d = sel_q + 3'd1;
    end
  end

  // NOTE: the captured word is a plain register bank, not a RAM. It is reset
  // so that a reset discards the previous conversion's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= 3'd0;
      len_q  <= 3'd0;
      mode_q <= 1'b0;
      din_q  <= 48'd0;
    end else begin
      sel_q  <= sel_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      din_q  <= din_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded purely from registers, so a reset clears them at once
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_o        = sel_q;
    sextet_o     = din_q[sel_q*6 +: 6];
    char_valid_o = (state_q == SEND);
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    char_out_o   = 8'h00;
    if (state_q == SEND)
      char_out_o = mode_q ? hex_char(sextet_o[3:0]) : b64_char(sextet_o);
  end

endmodule

// File: tb/tb_base64_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for base64_sequencer. The stimulus process pushes the expected
// characters and Done pulses into a queue. The monitor pops one entry for every
// handshake or Done cycle it sees and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_base64_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        mode_i;
  logic [2:0]  len_i;
  logic [47:0] din_i;
  logic        char_ready_i;
  logic [2:0]  sel_o;
  logic [5:0]  sextet_o;
  logic [7:0]  char_out_o;
  logic        char_valid_o;
  logic        busy_o;
  logic        done_o;

  base64_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .len_i        (len_i),
    .din_i        (din_i),
    .char_ready_i (char_ready_i),
    .sel_o        (sel_o),
    .sextet_o     (sextet_o),
    .char_out_o   (char_out_o),
    .char_valid_o (char_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [2:0] sel;
    logic [5:0] sextet;
    logic [7:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_char(input logic [2:0] sel, input logic [5:0] sx, input logic [7:0] ch);
    exp_t e;
    e.is_done = 1'b0; e.sel = sel; e.sextet = sx; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.sel = 3'd0; e.sextet = 6'd0; e.ch = 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: sample half a cycle away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (char_valid_o && char_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_char", {56'd0, char_out_o}, 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("kind_char", {63'd0, e.is_done}, 64'd0);
          check("char_out", {56'd0, char_out_o}, {56'd0, e.ch});
          check("char_sel", {61'd0, sel_o}, {61'd0, e.sel});
          check("char_sextet", {58'd0, sextet_o}, {58'd0, e.sextet});
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("kind_done", {63'd0, e.is_done}, 64'd1);
          check("done_no_valid", {63'd0, char_valid_o}, 64'd0);
        end
      end
    end
  end

  // Start is applied just after one edge and is accepted on the next edge.
  // The latency check follows one step after that edge.
  task automatic start_conv(input logic m, input logic [2:0] l, input logic [47:0] d);
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = m; len_i = l; din_i = d;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("latency_valid", {63'd0, char_valid_o}, 64'd1);
    check("start_sel0", {61'd0, sel_o}, 64'd0);
  endtask

  // Count valid cycles until Done, with a bound, then confirm the return to IDLE.
  task automatic wait_done(input int exp_cycles, input string name);
    int  cnt;
    bit  seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; break; end
      if (char_valid_o) cnt++;
    end
    check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({name, "_char_cycles"}, cnt, exp_cycles);
    @(negedge clk);
    check({name, "_idle_after"}, {62'd0, busy_o, done_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; len_i = 3'd0;
    din_i = 48'hFFFF_FFFF_FFFF; char_ready_i = 1'b1;
    #3;
    check("reset_outputs",
          {44'd0, sel_o, sextet_o, char_out_o, char_valid_o, busy_o, done_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    din_i = 48'd0;
    @(negedge clk);
    check("idle_after_reset", {62'd0, busy_o, char_valid_o}, 64'd0);

    // Base64 map corners: 0,1,25,26,51,52,62,63 -> A B Z a z 0 + /
    push_char(3'd0, 6'd0,  8'h41);
    push_char(3'd1, 6'd1,  8'h42);
    push_char(3'd2, 6'd25, 8'h5A);
    push_char(3'd3, 6'd26, 8'h61);
    push_char(3'd4, 6'd51, 8'h7A);
    push_char(3'd5, 6'd52, 8'h30);
    push_char(3'd6, 6'd62, 8'h2B);
    push_char(3'd7, 6'd63, 8'h2F);
    push_done();
    start_conv(1'b0, 3'd7, {6'd63, 6'd62, 6'd52, 6'd51, 6'd26, 6'd25, 6'd1, 6'd0});
    wait_done(8, "b64_full");

    // Hex map, upper bits ignored: 0x0A,0x3F,0x05,0x10 -> A F 5 0
    push_char(3'd0, 6'h0A, 8'h41);
    push_char(3'd1, 6'h3F, 8'h46);
    push_char(3'd2, 6'h05, 8'h35);
    push_char(3'd3, 6'h10, 8'h30);
    push_done();
    start_conv(1'b1, 3'd3, {24'hFFFFFF, 6'h10, 6'h05, 6'h3F, 6'h0A});
    wait_done(4, "hex_len3");

    // Backpressure at sel=1: 1,2,3,4 -> B C D E
    push_char(3'd0, 6'd1, 8'h42);
    push_char(3'd1, 6'd2, 8'h43);
    push_char(3'd2, 6'd3, 8'h44);
    push_char(3'd3, 6'd4, 8'h45);
    push_done();
    start_conv(1'b0, 3'd3, {24'd0, 6'd4, 6'd3, 6'd2, 6'd1});
    @(posedge clk); #1;
    char_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sel", {61'd0, sel_o}, 64'd1);
      check("stall_char", {55'd0, char_valid_o, char_out_o}, {55'd0, 1'b1, 8'h43});
    end
    @(posedge clk); #1;
    char_ready_i = 1'b1;
    wait_done(3, "backpressure");

    // Start pulsed mid-SEND with other data: 10,20,30 -> K U e unchanged
    push_char(3'd0, 6'd10, 8'h4B);
    push_char(3'd1, 6'd20, 8'h55);
    push_char(3'd2, 6'd30, 8'h65);
    push_done();
    start_conv(1'b0, 3'd2, {30'd0, 6'd30, 6'd20, 6'd10});
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = 1'b1; len_i = 3'd7; din_i = 48'hABCD_EF01_2345;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(1, "start_ignored");

    // Len=0: exactly one character (W0=63 -> '/')
    push_char(3'd0, 6'd63, 8'h2F);
    push_done();
    start_conv(1'b0, 3'd0, {42'h3FF_FFFF_FFFF, 6'd63});
    wait_done(1, "len0");

    // Reset at sel=4 in a hex run of 0..7: only 0..3 handshake, no Done
    push_char(3'd0, 6'd0, 8'h30);
    push_char(3'd1, 6'd1, 8'h31);
    push_char(3'd2, 6'd2, 8'h32);
    push_char(3'd3, 6'd3, 8'h33);
    start_conv(1'b1, 3'd7, {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0});
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_sel", {61'd0, sel_o}, 64'd4);
    rst = 1'b1; start_i = 1'b1; mode_i = 1'b0; len_i = 3'd5; din_i = 48'h1234_5678_9ABC;
    #1;
    check("midrun_reset_outputs",
          {44'd0, sel_o, sextet_o, char_out_o, char_valid_o, busy_o, done_o}, 64'd0);
    @(posedge clk); #1;
    check("start_during_reset", {62'd0, busy_o, char_valid_o}, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("idle_after_release", {61'd0, busy_o, char_valid_o, done_o}, 64'd0);
    check("queue_drained_reset", exp_q.size(), 64'd0);

    // Fresh conversion after reset: 5,6 -> F G
    push_char(3'd0, 6'd5, 8'h46);
    push_char(3'd1, 6'd6, 8'h47);
    push_done();
    start_conv(1'b0, 3'd1, {36'd0, 6'd6, 6'd5});
    wait_done(2, "post_reset");

    repeat (3) @(negedge clk);
    check("queue_drained_end", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/base64_sequencer.md
BASE64_SEQUENCER -- requirements
Module: base64_sequencer

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset; overrides every other input.
REQ-003 Start  in  1  request to begin a conversion; sampled only in IDLE.
REQ-004 Mode  in  1  0 = base64 character map, 1 = hex character map; captured on accepted Start.
REQ-005 Len  in  3  number of sextets to emit minus 1 (0..7); captured on accepted Start.
REQ-006 Din  in  48  eight packed sextets, W0 = Din[5:0] ... W7 = Din[47:42]; captured on accepted Start.
REQ-007 CharReady  in  1  downstream consumer can accept CharOut this cycle.
REQ-008 Sel  out  3  current sextet index {S2,S1,S0} of the internal 8-way 6-bit selector.
REQ-009 Sextet  out  6  captured word W[Sel] (selector output).
REQ-010 CharOut  out  8  ASCII character for Sextet under captured Mode.
REQ-011 CharValid  out  1  CharOut is valid.
REQ-012 Busy  out  1  high in SEND and DONE.
REQ-013 Done  out  1  single-cycle pulse after the last character handshake.

Function
REQ-014 States SHALL be IDLE, SEND, DONE.
REQ-015 IDLE: Start=1 at an edge captures Din, Mode, Len into internal registers, sets Sel=0, enters SEND; Start=0 stays in IDLE.
REQ-016 Start while in SEND or DONE SHALL be ignored, with no effect on captured data.
REQ-017 SEND: CharValid=1; a handshake occurs on an edge where CharValid=1 and CharReady=1.
REQ-018 On handshake with Sel != captured Len, Sel increments by 1 and the state stays SEND.
REQ-019 On handshake with Sel == captured Len, the state goes to DONE and Sel is held.
REQ-020 With CharValid=1 and CharReady=0, Sel, Sextet, and CharOut SHALL hold stable.
REQ-021 Latency: Start accepted at edge k gives CharValid=1 in the cycle after edge k.
REQ-022 Throughput: one character per cycle while CharReady=1; a conversion emits exactly Len+1 characters.
REQ-023 DONE: Done=1 and CharValid=0 for exactly one cycle, then IDLE unconditionally.
REQ-024 Sel SHALL never exceed captured Len and SHALL not wrap from 7 to 0 within a conversion.
REQ-025 Base64 map for value v: 0-25 -> 0x41+v, 26-51 -> 0x61+(v-26), 52-61 -> 0x30+(v-52), 62 -> 0x2B, 63 -> 0x2F.
REQ-026 Hex map uses n = Sextet[3:0] and ignores Sextet[5:4]: 0-9 -> 0x30+n, 10-15 -> 0x41+(n-10), uppercase.
REQ-027 When CharValid=0, CharOut SHALL be 8'h00; Sextet always reflects W[Sel] of the captured data.
REQ-028 Len=0 SHALL emit exactly one character (W0), then DONE.

Reset
REQ-029 Reset=1 SHALL immediately force state to IDLE, discard captured data (zeroed), and set Sel=0, Sextet=0, CharOut=8'h00, CharValid=0, Busy=0, Done=0.
REQ-030 Reset mid-conversion SHALL emit no further characters and no Done pulse; the first Start after deassertion behaves as a fresh conversion.
REQ-031 Start coincident with Reset=1 SHALL be ignored.

Verification
REQ-032 Mode=0, Len=7, sextets 0,1,25,26,51,52,62,63, CharReady=1 -> CharOut 'A','B','Z','a','z','0','+','/' on 8 consecutive cycles, Sel 0..7, Done one cycle later, then IDLE.
REQ-033 Mode=1, Len=3, sextets 0x0A,0x3F,0x05,0x10 -> 'A','F','5','0'; Done after the 4th character; Sel never exceeds 3.
REQ-034 Backpressure: CharReady=0 for 3 cycles while Sel=1 -> Sel=1 and CharOut held constant for those cycles; the sequence resumes without loss or duplication.
REQ-035 Start pulsed during SEND with different Din -> output sequence unchanged; Len=0 run -> a single character, then Done.
REQ-036 Reset asserted while Sel=4 in SEND -> all outputs 0 immediately with no Done; after release, a new Start with Len=1 emits exactly 2 characters.
